// File: rtl/seq_det_prog.sv
// Programmable-pattern bit-serial Mealy sequence detector with runtime length,
// pattern and overlap mode, plus a saturating match counter.
module seq_det_prog #(
    parameter int unsigned         MAX_LEN     = 8,
    parameter int unsigned         CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]  PAT_DEFAULT = MAX_LEN'(9),
    parameter int unsigned         LEN_DEFAULT = 4,
    parameter bit                  OVL_DEFAULT = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       in_bit,
    input  logic                       cfg_load,
    input  logic [MAX_LEN-1:0]         cfg_pattern,
    input  logic [$clog2(MAX_LEN):0]   cfg_len,
    input  logic                       cfg_overlap,
    input  logic                       cnt_clr,
    output logic                       match,
    output logic [CNT_W-1:0]           match_count,
    output logic                       cfg_err
);

    localparam int unsigned LEN_W    = $clog2(MAX_LEN) + 1;
    localparam int unsigned FILL_W   = $clog2(MAX_LEN);
    localparam int unsigned FILL_MAX = MAX_LEN - 1;

    // Only the newest MAX_LEN-1 accepted bits can ever reach the compare window.
    logic [MAX_LEN-2:0] hist;
    logic [FILL_W-1:0]  fill;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] len_mask;
    logic               bits_equal;
    logic               enough_bits;
    logic               cfg_bad;
    logic [CNT_W-1:0]   cnt_max;

    assign window = {hist, in_bit};
    assign cnt_max = {CNT_W{1'b1}};

    // Select the low len bits of the window for comparison.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            len_mask[i] = (LEN_W'(i) < len);
        end
    end

    assign bits_equal  = (((window ^ pat) & len_mask) == '0);
    assign enough_bits = ((LEN_W'(fill) + LEN_W'(1)) >= len);
    assign match       = in_valid & ~cfg_load & ~cfg_err & enough_bits & bits_equal;
    assign cfg_bad     = (cfg_len == '0) | (cfg_len > LEN_W'(MAX_LEN));

    // Active configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat     <= PAT_DEFAULT;
            len     <= LEN_W'(LEN_DEFAULT);
            ovl     <= OVL_DEFAULT;
            cfg_err <= 1'b0;
        end else if (cfg_load) begin
            pat     <= cfg_pattern;
            len     <= cfg_len;
            ovl     <= cfg_overlap;
            cfg_err <= cfg_bad;
        end
    end

    // Bit history; a non-overlapping match discards everything seen so far.
    always_ff @(posedge clk) begin
        if (reset || cfg_load) begin
            hist <= '0;
            fill <= '0;
        end else if (in_valid) begin
            hist <= window[MAX_LEN-2:0];
            if (match && !ovl) begin
                fill <= '0;
            end else if (fill != FILL_W'(FILL_MAX)) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

    // Saturating match counter; clear wins over increment.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            match_count <= '0;
        end else if (match && (match_count != cnt_max)) begin
            match_count <= match_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based reference model.
module tb_seq_det_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_bit = 1'b0;
    logic             cfg_load = 1'b0;
    logic [7:0]       cfg_pattern = '0;
    logic [3:0]       cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             cfg_err;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .match(match),
        .match_count(match_count), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the accepted bits since the last discard, newest at the back.
    logic   mq[$];
    logic [7:0] m_pat;
    int     m_len;
    bit     m_ovl;
    bit     m_err;
    int     m_cnt;

    function automatic logic model_match();
        logic wb;
        if (!in_valid || cfg_load || m_err) return 1'b0;
        if (mq.size() + 1 < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            wb = (k == 0) ? in_bit : mq[mq.size() - k];
            if (wb !== m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        logic mm;
        mm = model_match();
        if (reset) begin
            mq.delete();
            m_pat = 8'b0000_1001;
            m_len = 4;
            m_ovl = 1'b1;
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            if (cnt_clr) m_cnt = 0;
            else if (mm && m_cnt < CNT_MAX) m_cnt++;
            if (cfg_load) begin
                mq.delete();
                m_pat = cfg_pattern;
                m_len = int'(cfg_len);
                m_ovl = cfg_overlap;
                m_err = (cfg_len == 0) || (cfg_len > 4'(MAX_LEN));
            end else if (in_valid) begin
                mq.push_back(in_bit);
                if (mm && !m_ovl) mq.delete();
                while (mq.size() > MAX_LEN - 1) void'(mq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (!reset) check("match_model", int'(match), int'(model_match()));
            check("count_model", int'(match_count), m_cnt);
            check("cfg_err_model", int'(cfg_err), int'(m_err));
        end
    end

    // Driver tasks: entered and left 1 time unit after a rising edge.
    task automatic bit_in(input logic b, input logic expm, input logic clr = 1'b0);
        in_valid = 1'b1; in_bit = b; cnt_clr = clr;
        #1 check("match_lit", int'(match), int'(expm));
        @(posedge clk); #1;
        in_valid = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic idle_in(input logic b);
        in_valid = 1'b0; in_bit = b;
        #1 check("gap_match_lit", int'(match), 0);
        @(posedge clk); #1;
    endtask

    task automatic send_seq(input logic [15:0] bits, input int n, input logic [15:0] expm);
        for (int i = n - 1; i >= 0; i--) bit_in(bits[i], expm[i]);
    endtask

    task automatic load(input int len, input logic [7:0] pat, input logic ovl);
        cfg_load = 1'b1; cfg_len = 4'(len); cfg_pattern = pat; cfg_overlap = ovl;
        in_valid = 1'b1; in_bit = pat[0];
        #1 check("load_match_lit", int'(match), 0);
        @(posedge clk); #1;
        cfg_load = 1'b0; in_valid = 1'b0;
    endtask

    task automatic clr_cnt();
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("clr_lit", int'(match_count), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        started = 1'b1;
        check("reset_count_lit", int'(match_count), 0);
        check("reset_err_lit", int'(cfg_err), 0);

        // Default pattern 1001, overlapping.
        send_seq(16'b1001001, 7, 16'b0001001);
        check("default_count_lit", int'(match_count), 2);

        // Non-overlapping 1001.
        clr_cnt();
        load(4, 8'b1001, 1'b0);
        send_seq(16'b10010011001, 11, 16'b00010000001);
        check("nonovl_count_lit", int'(match_count), 2);

        // Valid gaps between bits.
        clr_cnt();
        load(4, 8'b1001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bit_in((i == 0 || i == 3), (i == 3));
            repeat (3) idle_in(1'b1);
        end
        check("gap_count_lit", int'(match_count), 1);

        // Reconfigure mid-stream.
        clr_cnt();
        send_seq(16'b10, 2, 16'b00);
        load(3, 8'b110, 1'b1);
        send_seq(16'b110110, 6, 16'b001001);
        check("reconf_count_lit", int'(match_count), 2);

        // Saturation and clear priority.
        clr_cnt();
        load(1, 8'b1, 1'b1);
        send_seq(16'b11111, 5, 16'b11111);
        check("sat_count_lit", int'(match_count), 3);
        bit_in(1'b1, 1'b1, 1'b1);
        check("clr_prio_lit", int'(match_count), 0);

        // Invalid lengths, then recovery.
        load(0, 8'b1, 1'b1);
        check("err_len0_lit", int'(cfg_err), 1);
        send_seq(16'b1111, 4, 16'b0000);
        check("err_frozen_lit", int'(match_count), 0);
        load(9, 8'hFF, 1'b1);
        check("err_len9_lit", int'(cfg_err), 1);
        load(2, 8'b01, 1'b1);
        check("err_clear_lit", int'(cfg_err), 0);
        send_seq(16'b01, 2, 16'b01);

        // Reset mid-sequence discards history.
        load(4, 8'b1001, 1'b1);
        send_seq(16'b100, 3, 16'b000);
        do_reset();
        bit_in(1'b1, 1'b0);
        send_seq(16'b001, 3, 16'b001);

        // Randomized run, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 299) == 0);
            cfg_load    = ($urandom_range(0, 39) == 0);
            cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 9))
                                                      : 4'($urandom_range(1, 3));
            cfg_pattern = 8'($urandom);
            cfg_overlap = 1'($urandom);
            cnt_clr     = ($urandom_range(0, 29) == 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            in_bit      = 1'($urandom);
            @(posedge clk); #1;
        end
        reset = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
